vga_timing_controller: RTL

Sequencer for the VGA sync path: divides the system clock to the pixel rate and runs the horizontal and vertical counters. It derives registered hsync, vsync and video_on from those counters and starts or stops scanning on whole-frame boundaries. It sits between the top-level clock domain and the pixel/colour generator, which consumes cnt_h, cnt_v, video_on and pixel_tick.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing_controller_pixel_tick_gen.sv | 33 +++
 rtl/vga_timing_controller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, counter width and FSM encoding
// for the VGA sync path.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT
                                 + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT
                                 + VGA_V_SYNC + VGA_V_BACK;

    localparam int   VGA_CLK_DIV  = 4;
    localparam logic VGA_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // True when lo <= c < lo + len.
    function automatic logic in_span(
        input logic [CNT_W-1:0] c,
        input int               lo,
        input int               len
    );
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_controller_pixel_tick_gen.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 while run is high, flags the
// advance edge and marks the first clk of each pixel.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic advance,
    output logic tick
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;

    assign advance = run && (div_q == LAST);
    // div_q is 0 on the clk right after a start or an advance edge
    assign tick    = run && (div_q == '0);

    // Divider counter, parked at 0 whenever scanning is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (!run || advance) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// VGA sync sequencer: run/stop FSM, horizontal/vertical counters and
// registered sync/video decode aligned with the counters they describe.
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter int   CLK_DIV   = VGA_CLK_DIV,
    parameter logic SYNC_POL  = VGA_SYNC_POL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             pixel_tick,
    output logic [CNT_W-1:0] cnt_h,
    output logic [CNT_W-1:0] cnt_v,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO   = H_VISIBLE + H_FRONT;
    localparam int VS_LO   = V_VISIBLE + V_FRONT;

    if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_total
        $error("vga_timing_controller: line/frame total exceeds counter range");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("vga_timing_controller: CLK_DIV must be at least 2");
    end

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] h_n;
    logic [CNT_W-1:0] v_n;
    logic             on_n;
    logic             fs_n;
    logic             video_n;
    logic             hs_n;
    logic             vs_n;
    logic             run;
    logic             advance;
    logic             tick;
    logic             h_end;
    logic             v_end;
    logic             wrap;

    assign run   = (state_q != IDLE);
    assign h_end = in_span(cnt_h, H_TOTAL - 1, 1);
    assign v_end = in_span(cnt_v, V_TOTAL - 1, 1);
    assign wrap  = advance && h_end && v_end;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .advance (advance),
        .tick    (tick)
    );

    // tick is a decode of the divider and state registers; it is 0 on
    // the clk after a stopping wrap because the state is already IDLE
    assign pixel_tick = tick;

    // Next state, next coordinates and the decode of those coordinates
    always_comb begin
        state_n = state_q;
        h_n     = cnt_h;
        v_n     = cnt_v;
        fs_n    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_n = RUN;
                    fs_n    = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_n = STOPPING;
                end
                fs_n = wrap;
            end
            STOPPING: begin
                if (wrap) begin
                    state_n = IDLE;
                end else if (enable) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (advance) begin
            if (h_end) begin
                h_n = '0;
                v_n = v_end ? '0 : cnt_v + CNT_W'(1);
            end else begin
                h_n = cnt_h + CNT_W'(1);
            end
        end
        if (state_n == IDLE) begin
            h_n = '0;
            v_n = '0;
        end

        on_n    = (state_n != IDLE);
        video_n = on_n
               && in_span(h_n, 0, H_VISIBLE)
               && in_span(v_n, 0, V_VISIBLE);
        hs_n    = (on_n && in_span(h_n, HS_LO, H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vs_n    = (on_n && in_span(v_n, VS_LO, V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    end

    // FSM state and scan counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_h   <= '0;
            cnt_v   <= '0;
        end else begin
            state_q <= state_n;
            cnt_h   <= h_n;
            cnt_v   <= v_n;
        end
    end

    // Output registers fed from the next-coordinate decode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else begin
            frame_start <= fs_n;
            video_on    <= video_n;
            hsync       <= hs_n;
            vsync       <= vs_n;
        end
    end

endmodule
